serial_alu32: RTL and testbench

- Bit-serial MIPS ALU. Evaluates one operand bit per clock, LSB first, using the same carry/less/set chain as the combinational ALU slices.
- The MSB step produces the set and overflow terms and feeds set back into result bit 0 for SLT. This is the sequential counterpart of the slice chain: the MSB slice's outputs drive the LSB slice's less input.
- Sits beside the combinational ALU as an area-reduced execution unit for the multi-cycle datapath.
- Start/busy/done handshake. The result is held until the next accepted start.

---
 rtl/serial_alu32_if.sv | 15 +
 rtl/serial_alu32.sv | 92 +++++++++
 tb/tb_serial_alu32.sv | 130 +++++++++++++
 3 files changed

// File: rtl/serial_alu32_if.sv
// serial_alu32_if: start/busy/done handshake and operand/result bus of the serial ALU
interface serial_alu32_if #(parameter int W = 32);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         v;
  logic         zero;
  modport master (output start, a, b, op, input busy, done, result, cout, v, zero);
  modport slave (input start, a, b, op, output busy, done, result, cout, v, zero);
endinterface

// File: rtl/serial_alu32.sv
// serial_alu32: bit-serial MIPS ALU, one operand bit per clock LSB first, start/busy/done handshake
module serial_alu32 #(
  parameter int W = 32
) (
  input logic           clk,
  input logic           rst,
  serial_alu32_if.slave bus
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q;
  logic [W-1:0]  a_q, b_q, acc_q, result_q;
  logic [2:0]    op_q;
  logic [CW-1:0] cnt_q;
  logic          c_q, busy_q, done_q, cout_q, v_q, zero_q;
  logic          inv, arith, bi, sum, c_d, r_bit, ovf, set, last;
  logic [W-1:0]  acc_d, result_d;
  always_comb begin
    inv      = op_q[2] & op_q[1];
    arith    = (op_q == 3'b010) | inv;
    bi       = b_q[0] ^ inv;
    sum      = a_q[0] ^ bi ^ c_q;
    c_d      = (a_q[0] & bi) | (a_q[0] & c_q) | (bi & c_q);
    r_bit    = op_q == 3'b000 ? a_q[0] & b_q[0] :
               op_q == 3'b001 ? a_q[0] | b_q[0] :
               arith ? sum : 1'b0;
    acc_d    = {r_bit, acc_q[W-1:1]};
    ovf      = c_q ^ c_d;
    set      = sum ^ ovf;
    result_d = op_q == 3'b111 ? {{(W-1){1'b0}}, set} : acc_d;
    last     = cnt_q == CW'(W - 1);
  end
  // Partial sums live in acc_q; result_q only changes on the MSB step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            c_q     <= bus.op[2] & bus.op[1];
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= result_d;
            cout_q   <= arith & ~op_q[0] ? c_d : 1'b0;
            v_q      <= arith & ~op_q[0] ? ovf : 1'b0;
            zero_q   <= result_d == '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.v      = v_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_alu32.sv
// tb_serial_alu32: directed vectors for the serial ALU at W=8 and W=32
module tb_serial_alu32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int seen;
  logic [7:0] held;
  serial_alu32_if #(.W(8)) i8 ();
  serial_alu32_if #(.W(32)) i32 ();
  serial_alu32 #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(i8));
  serial_alu32 #(.W(32)) dut32 (.clk(clk), .rst(rst), .bus(i32));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, output int l);
    @(negedge clk);
    i8.start = 1'b1;
    i8.a = a;
    i8.b = b;
    i8.op = op;
    l = 0;
    do begin
      @(negedge clk);
      i8.start = 1'b0;
      l++;
    end while (!i8.done && l < 40);
  endtask
  task automatic res8(input string tag, input logic [7:0] r, input logic c, input logic ov, input logic z);
    check({tag, " lat"}, lat, 9);
    check({tag, " result"}, i8.result, r);
    check({tag, " cout"}, i8.cout, c);
    check({tag, " v"}, i8.v, ov);
    check({tag, " zero"}, i8.zero, z);
  endtask
  initial begin
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.op = '0;
    i32.start = 1'b0; i32.a = '0; i32.b = '0; i32.op = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst busy", i8.busy, 0);
    check("rst done", i8.done, 0);
    check("rst result", i8.result, 0);
    check("rst zero", i8.zero, 1);
    check("rst cout", i8.cout, 0);
    op8(8'h7F, 8'h01, 3'b010, lat);
    res8("add", 8'h80, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("add done pulse", i8.done, 0);
    op8(8'h05, 8'h05, 3'b110, lat);
    res8("sub eq", 8'h00, 1'b1, 1'b0, 1'b1);
    op8(8'h03, 8'h05, 3'b110, lat);
    res8("sub borrow", 8'hFE, 1'b0, 1'b0, 1'b0);
    op8(8'hF0, 8'h3C, 3'b000, lat);
    res8("and", 8'h30, 1'b0, 1'b0, 1'b0);
    op8(8'h0F, 8'h30, 3'b001, lat);
    res8("or", 8'h3F, 1'b0, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 3'b011, lat);
    res8("undef", 8'h00, 1'b0, 1'b0, 1'b1);
    op8(8'h80, 8'h7F, 3'b111, lat);
    res8("slt lt", 8'h01, 1'b0, 1'b0, 1'b0);
    op8(8'h7F, 8'h80, 3'b111, lat);
    res8("slt ge", 8'h00, 1'b0, 1'b0, 1'b1);
    // start pulsed mid-run with different operands must be ignored
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'h10; i8.b = 8'h20; i8.op = 3'b010;
    @(negedge clk);
    i8.start = 1'b0;
    check("midrun busy", i8.busy, 1);
    repeat (2) @(negedge clk);
    i8.start = 1'b1; i8.a = 8'hFF; i8.b = 8'hFF; i8.op = 3'b000;
    @(negedge clk);
    i8.start = 1'b0;
    lat = 4;
    while (!i8.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res8("midrun", 8'h30, 1'b0, 1'b0, 1'b0);
    // start held high: done pulses exactly W+1 cycles apart
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'h01; i8.b = 8'h02; i8.op = 3'b010;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!i8.done && lat < 40);
    check("held first", lat, 9);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!i8.done && lat < 40);
    check("held period", lat, 9);
    i8.start = 1'b0;
    check("held result", i8.result, 8'h03);
    repeat (5) @(negedge clk);
    held = i8.result;
    check("idle stable", held, 8'h03);
    check("idle busy", i8.busy, 0);
    // reset on the fourth busy cycle aborts without a done pulse
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'h11; i8.b = 8'h22; i8.op = 3'b010;
    repeat (4) begin @(negedge clk); i8.start = 1'b0; end
    check("abort busy before", i8.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", i8.busy, 0);
    check("abort done", i8.done, 0);
    check("abort result", i8.result, 0);
    check("abort zero", i8.zero, 1);
    seen = 0;
    repeat (15) begin @(negedge clk); if (i8.done) seen++; end
    check("abort no done", seen, 0);
    op8(8'h02, 8'h03, 3'b010, lat);
    res8("after abort", 8'h05, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    i32.start = 1'b1; i32.a = 32'hFFFF_FFFF; i32.b = 32'h1; i32.op = 3'b010;
    lat = 0;
    do begin @(negedge clk); i32.start = 1'b0; lat++; end while (!i32.done && lat < 80);
    check("w32 lat", lat, 33);
    check("w32 result", i32.result, 0);
    check("w32 cout", i32.cout, 1);
    check("w32 v", i32.v, 0);
    check("w32 zero", i32.zero, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
